word_serializer: RTL and testbench

Write-side counterpart of the byte-assembling data register: takes one parallel word and emits it as a sequence of byte writes to byte-wide memory, one byte per accepted transfer, at consecutive addresses from a base. It sits between the datapath's 32-bit store source and the 8-bit memory write port. A ready-stall input lets the memory hold off transfers.

---
 rtl/word_serializer_pkg.sv | 15 +
 rtl/word_serializer.sv | 86 ++++++++
 tb/tb_word_serializer.sv | 195 +++++++++++++++++++
 3 files changed

// File: rtl/word_serializer_pkg.sv
// rtl/word_serializer_pkg.sv - shared types and constants for the word serializer
package word_serializer_pkg;

    localparam int BYTE_W = 8;

    localparam logic LSB_FIRST = 1'b0;
    localparam logic MSB_FIRST = 1'b1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/word_serializer.sv
// rtl/word_serializer.sv - splits one parallel word into consecutive byte writes
import word_serializer_pkg::*;

module word_serializer #(
    parameter int BYTES  = 4,
    parameter int ADDR_W = 8
) (
    input  logic                      i_clk,
    input  logic                      i_rst,
    input  logic                      i_start,
    input  logic [BYTE_W*BYTES-1:0]   i_word,
    input  logic [ADDR_W-1:0]         i_base_addr,
    input  logic                      i_order,
    input  logic                      i_mem_ready,
    output logic                      o_mem_we,
    output logic [ADDR_W-1:0]         o_mem_addr,
    output logic [BYTE_W-1:0]         o_mem_data,
    output logic                      o_busy,
    output logic                      o_done
);

    localparam int WORD_W = BYTE_W * BYTES;
    localparam int IDX_W  = (BYTES > 1) ? $clog2(BYTES) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BYTES - 1);

    state_t             r_state;
    logic [WORD_W-1:0]  r_shift;
    logic [ADDR_W-1:0]  r_addr;
    logic [IDX_W-1:0]   r_idx;
    logic               r_order;

    logic               w_send;
    logic [BYTE_W-1:0]  w_cur_byte;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= IDLE;
            r_shift <= '0;
            r_addr  <= '0;
            r_idx   <= '0;
            r_order <= LSB_FIRST;
        end else begin
            case (r_state)
                IDLE: begin
                    if (i_start) begin
                        r_shift <= i_word;
                        r_addr  <= i_base_addr;
                        r_order <= i_order;
                        r_idx   <= '0;
                        r_state <= SEND;
                    end
                end
                SEND: begin
                    // A stalled cycle leaves every register untouched so the bus stays stable
                    if (i_mem_ready) begin
                        r_addr  <= r_addr + ADDR_W'(1);
                        r_idx   <= r_idx + IDX_W'(1);
                        r_shift <= (r_order == MSB_FIRST) ? (r_shift << BYTE_W)
                                                          : (r_shift >> BYTE_W);
                        if (r_idx == LAST_IDX) begin
                            r_state <= DONE;
                        end
                    end
                end
                DONE: begin
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    // Outputs decode only registered state, so no input reaches an output in the same cycle
    assign w_send     = (r_state == SEND);
    assign w_cur_byte = (r_order == MSB_FIRST) ? r_shift[WORD_W-1 -: BYTE_W]
                                               : r_shift[BYTE_W-1:0];

    assign o_mem_we   = w_send;
    assign o_busy     = w_send;
    assign o_done     = (r_state == DONE);
    assign o_mem_addr = w_send ? r_addr : '0;
    assign o_mem_data = w_send ? w_cur_byte : '0;

endmodule

// File: tb/tb_word_serializer.sv
// tb/tb_word_serializer.sv - scoreboard bench for word_serializer
module tb_word_serializer;

    localparam int BYTES  = 4;
    localparam int ADDR_W = 8;

    logic               i_clk = 1'b0;
    logic               i_rst;
    logic               i_start;
    logic [8*BYTES-1:0] i_word;
    logic [ADDR_W-1:0]  i_base_addr;
    logic               i_order;
    logic               i_mem_ready;
    logic               o_mem_we;
    logic [ADDR_W-1:0]  o_mem_addr;
    logic [7:0]         o_mem_data;
    logic               o_busy;
    logic               o_done;

    word_serializer #(.BYTES(BYTES), .ADDR_W(ADDR_W)) dut (
        .i_clk(i_clk), .i_rst(i_rst), .i_start(i_start), .i_word(i_word),
        .i_base_addr(i_base_addr), .i_order(i_order), .i_mem_ready(i_mem_ready),
        .o_mem_we(o_mem_we), .o_mem_addr(o_mem_addr), .o_mem_data(o_mem_data),
        .o_busy(o_busy), .o_done(o_done)
    );

    always #5 i_clk = ~i_clk;

    typedef struct {
        logic [7:0] addr;
        logic [7:0] data;
        bit         last;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic push_word(input logic [31:0] w, input logic [7:0] b, input logic ord);
        exp_t e;
        int   k;
        for (int i = 0; i < BYTES; i++) begin
            k      = ord ? (BYTES - 1 - i) : i;
            e.addr = 8'((int'(b) + i) % 256);
            e.data = 8'((w >> (8 * k)) & 32'hFF);
            e.last = (i == BYTES - 1);
            sb.push_back(e);
        end
    endtask

    task automatic junk_inputs();
        i_start     = 1'($urandom_range(0, 1));
        i_word      = $urandom;
        i_base_addr = 8'($urandom);
        i_order     = 1'($urandom_range(0, 1));
    endtask

    // Entered and left at #1 after a rising edge with the DUT idle.
    // mode: 0 random ready, 1 ready always high, 2 stall on SEND cycles 2 and 3
    task automatic send_word(input logic [31:0] w, input logic [7:0] b, input logic ord,
                             input int mode);
        int   n;
        int   c;
        logic r;
        i_start     = 1'b1;
        i_word      = w;
        i_base_addr = b;
        i_order     = ord;
        i_mem_ready = 1'($urandom_range(0, 1));
        @(posedge i_clk);
        #1;
        push_word(w, b, ord);
        n = 0;
        c = 1;
        while (n < BYTES) begin
            junk_inputs();
            case (mode)
                1:       r = 1'b1;
                2:       r = !(c == 2 || c == 3);
                default: r = ($urandom_range(0, 3) != 0);
            endcase
            i_mem_ready = r;
            @(posedge i_clk);
            if (r) n++;
            c++;
            #1;
        end
        junk_inputs();
        i_mem_ready = 1'($urandom_range(0, 1));
        @(posedge i_clk);
        #1;
        i_start = 1'b0;
    endtask

    initial begin : monitor
        bit   exp_done;
        bit   nd;
        exp_t e;
        exp_done = 0;
        @(posedge i_clk);
        forever begin
            @(negedge i_clk);
            nd = 0;
            check("busy_vs_we", {31'd0, o_busy}, {31'd0, o_mem_we});
            if (o_mem_we) begin
                if (sb.size() == 0) begin
                    check("spurious_write", 32'd1, 32'd0);
                end else begin
                    check("mem_addr", {24'd0, o_mem_addr}, {24'd0, sb[0].addr});
                    check("mem_data", {24'd0, o_mem_data}, {24'd0, sb[0].data});
                    if (i_mem_ready && !i_rst) begin
                        e  = sb.pop_front();
                        nd = e.last;
                    end
                end
            end else begin
                check("idle_addr", {24'd0, o_mem_addr}, 32'd0);
                check("idle_data", {24'd0, o_mem_data}, 32'd0);
            end
            check("done", {31'd0, o_done}, {31'd0, exp_done});
            exp_done = nd;
        end
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin : stimulus
        i_rst       = 1'b1;
        i_start     = 1'b0;
        i_word      = '0;
        i_base_addr = '0;
        i_order     = 1'b0;
        i_mem_ready = 1'b0;
        repeat (2) @(posedge i_clk);
        #1;
        i_rst = 1'b0;
        @(posedge i_clk);
        #1;

        send_word(32'hA1B2C3D4, 8'h10, 1'b0, 1);
        send_word(32'hA1B2C3D4, 8'h10, 1'b1, 1);
        send_word(32'hA1B2C3D4, 8'h10, 1'b0, 2);
        send_word(32'h01020304, 8'hFE, 1'b0, 1);

        // Abandon a word mid-transfer: one byte taken, reset lands at the end of cycle 2
        i_start     = 1'b1;
        i_word      = 32'h55667788;
        i_base_addr = 8'h40;
        i_order     = 1'b0;
        i_mem_ready = 1'b1;
        @(posedge i_clk);
        #1;
        push_word(32'h55667788, 8'h40, 1'b0);
        i_start = 1'b0;
        @(posedge i_clk);
        #1;
        i_rst = 1'b1;
        @(posedge i_clk);
        #1;
        i_rst = 1'b0;
        sb.delete();
        i_mem_ready = 1'b0;
        repeat (2) @(posedge i_clk);
        #1;
        send_word(32'hCAFEF00D, 8'h80, 1'b1, 1);

        for (int t = 0; t < 40; t++) begin
            send_word($urandom, 8'($urandom), 1'($urandom_range(0, 1)), 0);
            repeat ($urandom_range(0, 2)) begin
                i_mem_ready = 1'($urandom_range(0, 1));
                @(posedge i_clk);
                #1;
            end
        end

        repeat (3) @(posedge i_clk);
        #1;
        check("leftover_bytes", 32'(sb.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
